mvu_job_scheduler: RTL and testbench

//  Job sequencer in front of one MVU. Buffers job descriptors from the host in a small FIFO and

---
 rtl/mvu_job_scheduler_if.sv | 33 +++
 rtl/mvu_job_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mvu_job_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mvu_job_scheduler_if.sv
// Host-descriptor, MVU-control and completion signals of the MVU job scheduler.
interface mvu_job_scheduler_if #(
  parameter int BCFG    = 256,
  parameter int BCNTDWN = 29,
  parameter int BID     = 8
);
  logic               desc_valid;
  logic               desc_ready;
  logic [BCFG-1:0]    desc_cfg;
  logic [BCNTDWN-1:0] desc_cntdwn;
  logic [BCFG-1:0]    mvu_cfg;
  logic [BCNTDWN-1:0] mvu_countdown;
  logic               mvu_start;
  logic               mvu_done;
  logic               cmpl_valid;
  logic               cmpl_ready;
  logic [BID-1:0]     cmpl_id;
  logic               cmpl_err;
  logic               busy;
  logic               irq;

  modport slave (
    input  desc_valid, desc_cfg, desc_cntdwn, mvu_done, cmpl_ready,
    output desc_ready, mvu_cfg, mvu_countdown, mvu_start,
           cmpl_valid, cmpl_id, cmpl_err, busy, irq
  );

  modport master (
    output desc_valid, desc_cfg, desc_cntdwn, mvu_done, cmpl_ready,
    input  desc_ready, mvu_cfg, mvu_countdown, mvu_start,
           cmpl_valid, cmpl_id, cmpl_err, busy, irq
  );
endinterface

// File: rtl/mvu_job_scheduler.sv
// Queues MVU job descriptors, launches them one at a time with a watchdog,
// and posts one completion record per job through a single-entry buffer.
module mvu_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int BCFG    = 256,
  parameter int BCNTDWN = 29,
  parameter int SLACK   = 16,
  parameter int BID     = 8
) (
  input  logic               clk,
  input  logic               rst,
  mvu_job_scheduler_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int BWD = BCNTDWN + 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_RUN, S_CMPL} state_t;

  logic [BCFG-1:0]    cfg_mem [DEPTH];
  logic [BCNTDWN-1:0] cnt_mem [DEPTH];
  logic [BID-1:0]     id_mem  [DEPTH];

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [BID-1:0]     next_id_q, next_id_d;
  logic [BCFG-1:0]    cfg_q, cfg_d;
  logic [BCNTDWN-1:0] cntdwn_q, cntdwn_d;
  logic [BID-1:0]     job_id_q, job_id_d;
  logic [BWD-1:0]     wd_q, wd_d;
  logic               start_q, start_d;
  logic               cmpl_valid_q, cmpl_valid_d;
  logic               cmpl_err_q, cmpl_err_d;
  logic [BID-1:0]     cmpl_id_q, cmpl_id_d;

  logic               full, empty, push, launch, bypass, pop, wr_en, cmpl_free;
  logic [BCFG-1:0]    head_cfg;
  logic [BCNTDWN-1:0] head_cnt;
  logic [BID-1:0]     head_id;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.desc_valid && !full;
  assign cmpl_free = !cmpl_valid_q || bus.cmpl_ready;
  assign launch    = (state_q == S_IDLE) && cmpl_free && (!empty || bus.desc_valid);
  // An idle scheduler with an empty queue takes the incoming descriptor directly,
  // so a job pushed at cycle t is in SETUP at t+1.
  assign bypass    = launch && empty;
  assign pop       = launch && !empty;
  assign wr_en     = push && !bypass;

  assign head_cfg  = empty ? bus.desc_cfg    : cfg_mem[rd_ptr_q];
  assign head_cnt  = empty ? bus.desc_cntdwn : cnt_mem[rd_ptr_q];
  assign head_id   = empty ? next_id_q       : id_mem[rd_ptr_q];

  assign bus.desc_ready    = !full;
  assign bus.mvu_cfg       = cfg_q;
  assign bus.mvu_countdown = cntdwn_q;
  assign bus.mvu_start     = start_q;
  assign bus.cmpl_valid    = cmpl_valid_q;
  assign bus.cmpl_id       = cmpl_id_q;
  assign bus.cmpl_err      = cmpl_err_q;
  assign bus.irq           = cmpl_valid_q;
  assign bus.busy          = (state_q != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      cfg_mem[wr_ptr_q] <= bus.desc_cfg;
      cnt_mem[wr_ptr_q] <= bus.desc_cntdwn;
      id_mem[wr_ptr_q]  <= next_id_q;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(wr_en);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    next_id_d    = next_id_q + BID'(push);
    state_d      = state_q;
    cfg_d        = cfg_q;
    cntdwn_d     = cntdwn_q;
    job_id_d     = job_id_q;
    wd_d         = wd_q;
    start_d      = 1'b0;
    cmpl_valid_d = cmpl_valid_q && !bus.cmpl_ready;
    cmpl_err_d   = cmpl_err_q;
    cmpl_id_d    = cmpl_id_q;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d  = S_SETUP;
          cfg_d    = head_cfg;
          cntdwn_d = head_cnt;
          job_id_d = head_id;
        end
      end
      S_SETUP: begin
        if (cntdwn_q == '0) begin
          state_d      = S_CMPL;
          cmpl_valid_d = 1'b1;
          cmpl_err_d   = 1'b1;
          cmpl_id_d    = job_id_q;
        end else begin
          // Watchdog is armed one cycle early and ticks through START, so it
          // hits zero exactly countdown+SLACK cycles after the start pulse.
          state_d = S_START;
          start_d = 1'b1;
          wd_d    = {1'b0, cntdwn_q} + BWD'(SLACK);
        end
      end
      S_START: begin
        state_d = S_RUN;
        wd_d    = wd_q - BWD'(1);
      end
      S_RUN: begin
        if (bus.mvu_done || wd_q == BWD'(1)) begin
          state_d      = S_CMPL;
          cmpl_valid_d = 1'b1;
          cmpl_err_d   = !bus.mvu_done;
          cmpl_id_d    = job_id_q;
        end
        wd_d = wd_q - BWD'(1);
      end
      S_CMPL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      next_id_q    <= '0;
      cfg_q        <= '0;
      cntdwn_q     <= '0;
      job_id_q     <= '0;
      wd_q         <= '0;
      start_q      <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_err_q   <= 1'b0;
      cmpl_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      next_id_q    <= next_id_d;
      cfg_q        <= cfg_d;
      cntdwn_q     <= cntdwn_d;
      job_id_q     <= job_id_d;
      wd_q         <= wd_d;
      start_q      <= start_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_err_q   <= cmpl_err_d;
      cmpl_id_q    <= cmpl_id_d;
    end
  end
endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Randomized bench for mvu_job_scheduler against a job-timeline reference model
// (queue of descriptors, launch/start/completion cycles derived from the job rules).
module tb_mvu_job_scheduler;
  localparam int DEPTH = 4, BCFG = 256, BCNTDWN = 29, SLACK = 16, BID = 8;
  localparam int NCYC  = 3200;

  typedef struct {
    logic [BCFG-1:0]    cfg;
    logic [BCNTDWN-1:0] cnt;
    logic [BID-1:0]     id;
  } desc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvu_job_scheduler_if #(.BCFG(BCFG), .BCNTDWN(BCNTDWN), .BID(BID)) bus_if ();

  mvu_job_scheduler #(
    .DEPTH(DEPTH), .BCFG(BCFG), .BCNTDWN(BCNTDWN), .SLACK(SLACK), .BID(BID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // reference model state
  desc_t              mq[$];
  logic [BID-1:0]     m_next_id;
  bit                 m_active, m_posted;
  int                 m_launch, m_cmpl_cyc;
  logic [BCFG-1:0]    m_cfg;
  logic [BCNTDWN-1:0] m_cnt;
  logic [BID-1:0]     m_cur_id;
  bit                 m_pend, m_pend_err;
  logic [BID-1:0]     m_pend_id;

  task automatic check_eq(input string tag, input logic [BCFG-1:0] got, input logic [BCFG-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next_id  = '0;
    m_active   = 1'b0;
    m_posted   = 1'b0;
    m_launch   = -100;
    m_cmpl_cyc = -100;
    m_cfg      = '0;
    m_cnt      = '0;
    m_cur_id   = '0;
    m_pend     = 1'b0;
    m_pend_err = 1'b0;
    m_pend_id  = '0;
  endtask

  task automatic post(input bit err);
    m_posted   = 1'b1;
    m_cmpl_cyc = cyc + 1;
    m_pend     = 1'b1;
    m_pend_err = err;
    m_pend_id  = m_cur_id;
  endtask

  // Advance the model by one cycle given that cycle's accepted inputs.
  task automatic model_step(input bit push, input bit ack, input bit done,
                            input logic [BCFG-1:0] cfg, input logic [BCNTDWN-1:0] cnt);
    bit    idle_now = !m_active;
    bit    pend_now = m_pend;
    int    expiry   = m_launch + 1 + int'(m_cnt) + SLACK;
    desc_t d;
    if (pend_now && ack) begin
      $display("cmpl id=%0d err=%0d accepted at cyc %0d", m_pend_id, m_pend_err, cyc);
      m_pend = 1'b0;
    end
    if (m_active && !m_posted) begin
      if (m_cnt == '0) begin
        if (cyc == m_launch + 1) post(1'b1);
      end else if (done && cyc >= m_launch + 3 && cyc <= expiry) begin
        post(1'b0);
      end else if (cyc == expiry) begin
        post(1'b1);
      end
    end
    if (push) begin
      d.cfg = cfg; d.cnt = cnt; d.id = m_next_id;
      mq.push_back(d);
      m_next_id = m_next_id + 1'b1;
    end
    if (m_active && m_posted && cyc == m_cmpl_cyc) m_active = 1'b0;
    if (idle_now && mq.size() > 0 && (!pend_now || ack)) begin
      d          = mq.pop_front();
      m_active   = 1'b1;
      m_posted   = 1'b0;
      m_launch   = cyc;
      m_cfg      = d.cfg;
      m_cnt      = d.cnt;
      m_cur_id   = d.id;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_desc_ready"}, BCFG'(bus_if.desc_ready), BCFG'(1));
    check_eq({tag, "_busy"},       BCFG'(bus_if.busy), '0);
    check_eq({tag, "_mvu_start"},  BCFG'(bus_if.mvu_start), '0);
    check_eq({tag, "_mvu_cfg"},    bus_if.mvu_cfg, '0);
    check_eq({tag, "_mvu_cntdwn"}, BCFG'(bus_if.mvu_countdown), '0);
    check_eq({tag, "_cmpl_valid"}, BCFG'(bus_if.cmpl_valid), '0);
    check_eq({tag, "_cmpl_id"},    BCFG'(bus_if.cmpl_id), '0);
    check_eq({tag, "_cmpl_err"},   BCFG'(bus_if.cmpl_err), '0);
    check_eq({tag, "_irq"},        BCFG'(bus_if.irq), '0);
  endtask

  function automatic logic [BCFG-1:0] rand_cfg();
    logic [BCFG-1:0] v;
    for (int i = 0; i < BCFG / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  int push_pct[4] = '{30, 85, 60, 45};
  int ack_pct[4]  = '{85, 50, 8, 95};

  initial begin
    int  done_at;
    int  phase;
    int  n_rst;
    int  mode;
    bit  exp_ready;
    bit  exp_start;
    done_at = -1;
    n_rst   = 0;
    bus_if.desc_valid  = 1'b0;
    bus_if.desc_cfg    = '0;
    bus_if.desc_cntdwn = '0;
    bus_if.mvu_done    = 1'b0;
    bus_if.cmpl_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      rst   = 1'b0;
      cyc   = n;
      phase = n / (NCYC / 4);
      if (phase == 1 && m_active && !m_posted && n >= m_launch + 3 && mq.size() >= 2 &&
          n_rst < 3 && $urandom_range(0, 3) == 0) begin
        n_rst++;
        rst = 1'b1;
        bus_if.desc_valid = 1'b0;
        bus_if.mvu_done   = 1'b0;
        bus_if.cmpl_ready = 1'b0;
        done_at = -1;
        @(negedge clk);
        $display("reset in RUN at cyc %0d with %0d queued", n, mq.size());
        check_reset_vals("rst_run");
        model_reset();
        continue;
      end

      bus_if.desc_valid  = ($urandom_range(0, 99) < push_pct[phase]);
      bus_if.desc_cfg    = rand_cfg();
      bus_if.desc_cntdwn = ($urandom_range(0, 3) == 0) ? '0 : BCNTDWN'($urandom_range(1, 8));
      bus_if.cmpl_ready  = ($urandom_range(0, 99) < ack_pct[phase]);
      bus_if.mvu_done    = (n == done_at) || ($urandom_range(0, 24) == 0);

      @(negedge clk);
      exp_ready = (mq.size() < DEPTH);
      exp_start = m_active && (m_cnt != '0) && (n == m_launch + 2);
      check_eq("desc_ready", BCFG'(bus_if.desc_ready), BCFG'(exp_ready));
      check_eq("busy",       BCFG'(bus_if.busy), BCFG'(m_active || mq.size() > 0));
      check_eq("mvu_start",  BCFG'(bus_if.mvu_start), BCFG'(exp_start));
      check_eq("mvu_cfg",    bus_if.mvu_cfg, m_cfg);
      check_eq("mvu_cntdwn", BCFG'(bus_if.mvu_countdown), BCFG'(m_cnt));
      check_eq("cmpl_valid", BCFG'(bus_if.cmpl_valid), BCFG'(m_pend));
      check_eq("irq",        BCFG'(bus_if.irq), BCFG'(m_pend));
      if (m_pend) begin
        check_eq("cmpl_id",  BCFG'(bus_if.cmpl_id), BCFG'(m_pend_id));
        check_eq("cmpl_err", BCFG'(bus_if.cmpl_err), BCFG'(m_pend_err));
      end

      // MVU responder plan: early done, done on expiry cycle, done one cycle late, or none.
      if (exp_start) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0:       done_at = n + $urandom_range(1, int'(m_cnt) + 4);
          1:       done_at = n + int'(m_cnt) + SLACK - 1;
          2:       done_at = n + int'(m_cnt) + SLACK;
          default: done_at = -1;
        endcase
      end

      model_step(bus_if.desc_valid && exp_ready, bus_if.cmpl_ready, bus_if.mvu_done,
                 bus_if.desc_cfg, bus_if.desc_cntdwn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
